// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//
// Raster timing generator for the 640x480@60 Hz VGA path, clocked by the
// 25 MHz pixel clock. Two free-running position counters (h_cnt, v_cnt)
// walk the raster. Every output is a registered decode of the current
// counter values, so all outputs lag the counters by exactly one clock.
//
// The block is free-running. It has no valid/ready handshake, no enable
// and no back-pressure. Downstream stages consume the outputs on every
// clock.
//
// Ports:
//   vga_clk      in   pixel clock; all logic runs on its rising edge
//   rst          in   asynchronous, active-high reset
//   hsync        out  horizontal sync, active low
//   vsync        out  vertical sync, active low
//   de           out  high while the output position is a visible pixel
//   addr_h [11:0] out visible column 1..H_ACTIVE, 0 when de=0
//   addr_v [11:0] out visible line   1..V_ACTIVE, 0 when de=0
//   frame_start  out  one-cycle pulse at raster position (0,0)
//
// H_TOTAL and V_TOTAL must each be at most 4096 so that the 12-bit
// counters can hold every position.

module vga_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10
) (
  input  logic        vga_clk,
  input  logic        rst,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] addr_h,
  output logic [11:0] addr_v,
  output logic        frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

  // The window bounds are compared at 13 bits. This lets an active region
  // that ends exactly at 4096 still be represented.
  localparam logic [12:0] H_SYNC_END = 13'(H_SYNC);
  localparam logic [12:0] V_SYNC_END = 13'(V_SYNC);
  localparam logic [12:0] H_ACT_LO   = 13'(H_SYNC + H_BACK);
  localparam logic [12:0] H_ACT_HI   = 13'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [12:0] V_ACT_LO   = 13'(V_SYNC + V_BACK);
  localparam logic [12:0] V_ACT_HI   = 13'(V_SYNC + V_BACK + V_ACTIVE);

  // The coordinate is cnt - window_start + 1. The two constants are folded
  // into a single offset, and the subtraction wraps at 12 bits.
  localparam logic [11:0] H_OFS = 12'(H_SYNC + H_BACK - 1);
  localparam logic [11:0] V_OFS = 12'(V_SYNC + V_BACK - 1);

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;

  logic        h_wrap;
  logic        h_act;
  logic        v_act;
  logic        de_nxt;
  logic        hsync_nxt;
  logic        vsync_nxt;
  logic        fs_nxt;
  logic [11:0] addr_h_nxt;
  logic [11:0] addr_v_nxt;

  // Decode the current counter position. The result is registered below,
  // which is where the one-clock output latency comes from.
  always_comb begin
    h_wrap     = (h_cnt == H_LAST);
    hsync_nxt  = ({1'b0, h_cnt} >= H_SYNC_END);
    vsync_nxt  = ({1'b0, v_cnt} >= V_SYNC_END);
    h_act      = ({1'b0, h_cnt} >= H_ACT_LO) && ({1'b0, h_cnt} < H_ACT_HI);
    v_act      = ({1'b0, v_cnt} >= V_ACT_LO) && ({1'b0, v_cnt} < V_ACT_HI);
    de_nxt     = h_act && v_act;
    fs_nxt     = (h_cnt == 12'd0) && (v_cnt == 12'd0);
    addr_h_nxt = 12'd0;
    addr_v_nxt = 12'd0;
    if (de_nxt) begin
      addr_h_nxt = h_cnt - H_OFS;
      addr_v_nxt = v_cnt - V_OFS;
    end
  end

  // Position counters. v_cnt advances only on the clock where h_cnt wraps.
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      h_cnt <= 12'd0;
      v_cnt <= 12'd0;
    end else begin
      if (h_wrap) begin
        h_cnt <= 12'd0;
        v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
      end else begin
        h_cnt <= h_cnt + 12'd1;
      end
    end
  end

  // Output register. Reset values are the idle (inactive) levels.
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      addr_h      <= 12'd0;
      addr_v      <= 12'd0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      de          <= de_nxt;
      addr_h      <= addr_h_nxt;
      addr_v      <= addr_v_nxt;
      frame_start <= fs_nxt;
    end
  end

endmodule
